scariv_valu_exec_pipe: RTL



---
 rtl/scariv_valu_exec_pipe_if.sv | 44 ++++
 rtl/scariv_valu_exec_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_valu_exec_pipe_if.sv
// rtl/scariv_valu_exec_pipe_if.sv - issue, register-write, done and flush bundle of the VALU execute pipe
interface scariv_valu_exec_pipe_if #(
  parameter int DLEN_W   = 128,
  parameter int CMT_ID_W = 6,
  parameter int GRP_ID_W = 4,
  parameter int RNID_W   = 7
);
  logic                i_iss_valid;
  logic [CMT_ID_W-1:0] i_iss_cmt_id;
  logic [GRP_ID_W-1:0] i_iss_grp_id;
  logic [2:0]          i_iss_op;
  logic [1:0]          i_iss_sew;
  logic                i_iss_first;
  logic                i_iss_last;
  logic [DLEN_W-1:0]   i_iss_rs1;
  logic [DLEN_W-1:0]   i_iss_rs2;
  logic [RNID_W-1:0]   i_iss_wr_rnid;
  logic                o_stall;
  logic                o_wr_valid;
  logic [RNID_W-1:0]   o_wr_rnid;
  logic [DLEN_W-1:0]   o_wr_data;
  logic                o_done_valid;
  logic [CMT_ID_W-1:0] o_done_cmt_id;
  logic [GRP_ID_W-1:0] o_done_grp_id;
  logic                i_done_ready;
  logic                i_commit_flush;
  logic                i_br_flush;
  logic [CMT_ID_W-1:0] i_br_cmt_id;
  logic [GRP_ID_W-1:0] i_br_grp_id;

  modport master (
    output i_iss_valid, i_iss_cmt_id, i_iss_grp_id, i_iss_op, i_iss_sew, i_iss_first,
           i_iss_last, i_iss_rs1, i_iss_rs2, i_iss_wr_rnid, i_done_ready,
           i_commit_flush, i_br_flush, i_br_cmt_id, i_br_grp_id,
    input  o_stall, o_wr_valid, o_wr_rnid, o_wr_data, o_done_valid, o_done_cmt_id, o_done_grp_id
  );

  modport slave (
    input  i_iss_valid, i_iss_cmt_id, i_iss_grp_id, i_iss_op, i_iss_sew, i_iss_first,
           i_iss_last, i_iss_rs1, i_iss_rs2, i_iss_wr_rnid, i_done_ready,
           i_commit_flush, i_br_flush, i_br_cmt_id, i_br_grp_id,
    output o_stall, o_wr_valid, o_wr_rnid, o_wr_data, o_done_valid, o_done_cmt_id, o_done_grp_id
  );
endinterface

// File: rtl/scariv_valu_exec_pipe.sv
// rtl/scariv_valu_exec_pipe.sv - two-stage vector ALU execute pipe (EX1 operand latch, EX2 result latch)
// Reduction sum is built only when SCARIV_VALU_REDSUM_EN is defined; otherwise op 5 runs as ADD.
module scariv_valu_exec_pipe #(
  parameter int DLEN_W   = 128,
  parameter int CMT_ID_W = 6,
  parameter int GRP_ID_W = 4,
  parameter int RNID_W   = 7
) (
  input logic i_clk,
  input logic i_reset,
  scariv_valu_exec_pipe_if.slave bus
);
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
`ifdef SCARIV_VALU_REDSUM_EN
  localparam logic [2:0] OP_REDSUM = 3'd5;
`endif

  function automatic logic is_younger(input logic [CMT_ID_W-1:0] cmt, input logic [GRP_ID_W-1:0] grp,
                                      input logic [CMT_ID_W-1:0] br_cmt, input logic [GRP_ID_W-1:0] br_grp);
    if (cmt == br_cmt) return grp > br_grp;
    if (cmt[CMT_ID_W-1] == br_cmt[CMT_ID_W-1]) return cmt[CMT_ID_W-2:0] > br_cmt[CMT_ID_W-2:0];
    return cmt[CMT_ID_W-2:0] < br_cmt[CMT_ID_W-2:0];
  endfunction

  // SUB is rs2 - rs1; every lane wraps on its own with no carry into its neighbour.
  function automatic logic [DLEN_W-1:0] lane_addsub(input logic [DLEN_W-1:0] a, input logic [DLEN_W-1:0] b,
                                                    input logic sub, input logic [1:0] sew);
    logic [DLEN_W-1:0] r;
    r = '0;
    case (sew)
      2'd0: for (int i = 0; i < DLEN_W/8; i++)
              r[i*8 +: 8] = sub ? b[i*8 +: 8] - a[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
      2'd1: for (int i = 0; i < DLEN_W/16; i++)
              r[i*16 +: 16] = sub ? b[i*16 +: 16] - a[i*16 +: 16] : a[i*16 +: 16] + b[i*16 +: 16];
      2'd2: for (int i = 0; i < DLEN_W/32; i++)
              r[i*32 +: 32] = sub ? b[i*32 +: 32] - a[i*32 +: 32] : a[i*32 +: 32] + b[i*32 +: 32];
      default: for (int i = 0; i < DLEN_W/64; i++)
              r[i*64 +: 64] = sub ? b[i*64 +: 64] - a[i*64 +: 64] : a[i*64 +: 64] + b[i*64 +: 64];
    endcase
    return r;
  endfunction

`ifdef SCARIV_VALU_REDSUM_EN
  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 64'h0000_0000_0000_00ff;
      2'd1:    return 64'h0000_0000_0000_ffff;
      2'd2:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

  function automatic logic [63:0] lane_sum(input logic [DLEN_W-1:0] v, input logic [1:0] sew);
    logic [63:0] s;
    s = '0;
    case (sew)
      2'd0:    for (int i = 0; i < DLEN_W/8; i++)  s = s + 64'(v[i*8 +: 8]);
      2'd1:    for (int i = 0; i < DLEN_W/16; i++) s = s + 64'(v[i*16 +: 16]);
      2'd2:    for (int i = 0; i < DLEN_W/32; i++) s = s + 64'(v[i*32 +: 32]);
      default: for (int i = 0; i < DLEN_W/64; i++) s = s + v[i*64 +: 64];
    endcase
    return s;
  endfunction
`endif

  logic                ex1_valid;
  logic [CMT_ID_W-1:0] ex1_cmt_id;
  logic [GRP_ID_W-1:0] ex1_grp_id;
  logic [2:0]          ex1_op;
  logic [1:0]          ex1_sew;
  logic                ex1_first;
  logic                ex1_last;
  logic [DLEN_W-1:0]   ex1_rs1;
  logic [DLEN_W-1:0]   ex1_rs2;
  logic [RNID_W-1:0]   ex1_rnid;

  logic                ex2_valid;
  logic [CMT_ID_W-1:0] ex2_cmt_id;
  logic [GRP_ID_W-1:0] ex2_grp_id;
  logic                ex2_wr;
  logic                ex2_last;
  logic [RNID_W-1:0]   ex2_rnid;
  logic [DLEN_W-1:0]   ex2_data;

  logic                stall;
  logic                iss_kill;
  logic                ex1_kill;
  logic                ex2_kill;
  logic [DLEN_W-1:0]   ex1_result;
  logic                ex1_wr;

  assign stall    = ex2_valid & ex2_last & ~bus.i_done_ready;
  assign iss_kill = bus.i_br_flush & is_younger(bus.i_iss_cmt_id, bus.i_iss_grp_id, bus.i_br_cmt_id, bus.i_br_grp_id);
  assign ex1_kill = bus.i_br_flush & ex1_valid & is_younger(ex1_cmt_id, ex1_grp_id, bus.i_br_cmt_id, bus.i_br_grp_id);
  assign ex2_kill = bus.i_br_flush & ex2_valid & is_younger(ex2_cmt_id, ex2_grp_id, bus.i_br_cmt_id, bus.i_br_grp_id);

`ifdef SCARIV_VALU_REDSUM_EN
  logic [63:0]         r_acc;
  logic [63:0]         acc_next;
  logic [CMT_ID_W-1:0] acc_cmt_id;
  logic [GRP_ID_W-1:0] acc_grp_id;
`else
  logic                unused_first;
  assign unused_first = ex1_first;
`endif

  always_comb begin
    ex1_result = lane_addsub(ex1_rs1, ex1_rs2, 1'b0, ex1_sew);
    ex1_wr     = 1'b1;
`ifdef SCARIV_VALU_REDSUM_EN
    acc_next   = r_acc;
`endif
    case (ex1_op)
      OP_SUB: ex1_result = lane_addsub(ex1_rs1, ex1_rs2, 1'b1, ex1_sew);
      OP_AND: ex1_result = ex1_rs1 & ex1_rs2;
      OP_OR:  ex1_result = ex1_rs1 | ex1_rs2;
      OP_XOR: ex1_result = ex1_rs1 ^ ex1_rs2;
`ifdef SCARIV_VALU_REDSUM_EN
      OP_REDSUM: begin
        acc_next   = ((ex1_first ? (ex1_rs1[63:0] & sew_mask(ex1_sew)) : r_acc)
                      + lane_sum(ex1_rs2, ex1_sew)) & sew_mask(ex1_sew);
        ex1_wr     = ex1_last;
        ex1_result = DLEN_W'(acc_next);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex1_valid  <= 1'b0;
      ex1_cmt_id <= '0;
      ex1_grp_id <= '0;
      ex1_op     <= '0;
      ex1_sew    <= '0;
      ex1_first  <= 1'b0;
      ex1_last   <= 1'b0;
      ex1_rs1    <= '0;
      ex1_rs2    <= '0;
      ex1_rnid   <= '0;
    end else if (bus.i_commit_flush) begin
      ex1_valid <= 1'b0;
    end else if (!stall) begin
      ex1_valid <= bus.i_iss_valid & ~iss_kill;
      if (bus.i_iss_valid) begin
        ex1_cmt_id <= bus.i_iss_cmt_id;
        ex1_grp_id <= bus.i_iss_grp_id;
        ex1_op     <= bus.i_iss_op;
        ex1_sew    <= bus.i_iss_sew;
        ex1_first  <= bus.i_iss_first;
        ex1_last   <= bus.i_iss_last;
        ex1_rs1    <= bus.i_iss_rs1;
        ex1_rs2    <= bus.i_iss_rs2;
        ex1_rnid   <= bus.i_iss_wr_rnid;
      end
    end else if (ex1_kill) begin
      ex1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex2_valid  <= 1'b0;
      ex2_cmt_id <= '0;
      ex2_grp_id <= '0;
      ex2_wr     <= 1'b0;
      ex2_last   <= 1'b0;
      ex2_rnid   <= '0;
      ex2_data   <= '0;
    end else if (bus.i_commit_flush) begin
      ex2_valid <= 1'b0;
    end else if (!stall) begin
      ex2_valid <= ex1_valid & ~ex1_kill;
      if (ex1_valid) begin
        ex2_cmt_id <= ex1_cmt_id;
        ex2_grp_id <= ex1_grp_id;
        ex2_wr     <= ex1_wr;
        ex2_last   <= ex1_last;
        ex2_rnid   <= ex1_rnid;
        ex2_data   <= ex1_result;
      end
    end else if (ex2_kill) begin
      ex2_valid <= 1'b0;
    end
  end

`ifdef SCARIV_VALU_REDSUM_EN
  // The accumulator owner is remembered so a branch kill can drop a younger partial sum.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc      <= '0;
      acc_cmt_id <= '0;
      acc_grp_id <= '0;
    end else if (bus.i_commit_flush) begin
      r_acc <= '0;
    end else if (!stall && ex1_valid && !ex1_kill && ex1_op == OP_REDSUM) begin
      r_acc <= acc_next;
      if (ex1_first) begin
        acc_cmt_id <= ex1_cmt_id;
        acc_grp_id <= ex1_grp_id;
      end
    end else if (bus.i_br_flush && is_younger(acc_cmt_id, acc_grp_id, bus.i_br_cmt_id, bus.i_br_grp_id)) begin
      r_acc <= '0;
    end
  end
`endif

  assign bus.o_stall       = stall;
  assign bus.o_wr_valid    = ex2_valid & ex2_wr & ~stall;
  assign bus.o_wr_rnid     = ex2_rnid;
  assign bus.o_wr_data     = ex2_data;
  assign bus.o_done_valid  = ex2_valid & ex2_last;
  assign bus.o_done_cmt_id = ex2_cmt_id;
  assign bus.o_done_grp_id = ex2_grp_id;

  always @(posedge i_clk) begin
    if (!i_reset) assert (!(bus.i_iss_valid && stall));
  end
endmodule
